prog_word_loader: RTL and testbench
===================================

Name: prog_word_loader

Overview:
- Upstream feeder for the 1024x32 distributed RAM (clk, write_enable, addr[9:0], data_write[31:0]).
- Consumes a byte stream from the UART receiver and assembles little-endian 32-bit words.
- Issues one single-cycle RAM write per completed word, at consecutive addresses.
- Used to load program/data images into core memory before the core is released.

Parameters:
- ADDR_WIDTH, 10, RAM address width; capacity is 2**ADDR_WIDTH words.
- BASE_ADDR, 0, first RAM address written.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- start  in  1  one-cycle pulse; re-arms the loader from DONE or ERR.
- write_enable  out  1  RAM write strobe, one cycle per word.
- addr  out  ADDR_WIDTH  RAM write address.
- data_write  out  32  RAM write data.
- busy  out  1  high while in LEN or DATA after the first byte is taken.
- done  out  1  high in DONE.
- err  out  1  high in ERR (length exceeds capacity).
- loaded_words  out  ADDR_WIDTH+1  words written so far in the current load.

Behaviour:
- Stream format:
  - 4-byte little-endian word count N, then N words.
  - Each word is 4 bytes, little-endian: first byte goes to [7:0], fourth byte to [31:24].
- States: LEN, DATA, DONE, ERR.
- Reset (async, rstn=0): state=LEN, byte counter=0, word index=0. All outputs 0: write_enable, addr, data_write, busy, done, err, loaded_words. RAM contents are not touched.
- Reset mid-load: abandons the load immediately. Words already written remain in RAM. The next byte after release is treated as count byte 0.
- LEN:
  - Each rx_valid shifts a byte into the count register; the byte counter increments mod 4.
  - On the 4th byte:
    - N > 2**ADDR_WIDTH - BASE_ADDR -> ERR.
    - N == 0 -> DONE.
    - otherwise -> DATA.
- DATA:
  - Bytes are assembled into the word register.
  - On the 4th byte, accepted at edge t: in the cycle after edge t, write_enable=1, addr=BASE_ADDR+index, data_write=assembled word, for exactly one cycle.
  - index and loaded_words increment at the same edge that asserts write_enable.
  - When index reaches N -> DONE. done goes high in the cycle after the last write_enable pulse.
- Back-to-back rx_valid on every cycle is supported with no byte loss. Write latency is fixed at 1 cycle after the completing byte.
- busy=1 from the first accepted byte until leaving DATA. busy=0 in DONE and ERR, and in LEN before any byte.
- DONE and ERR:
  - rx_valid is ignored; no writes occur.
  - done/err hold until start.
  - start clears done/err, byte counter, index and loaded_words, and returns to LEN.
  - start in LEN or DATA is ignored.
- Simultaneous start and rx_valid in DONE/ERR: start wins and the byte is dropped.
- Address arithmetic is modulo 2**ADDR_WIDTH; the ERR check guarantees no wrap occurs within a legal load.
- addr and data_write hold their last written values between pulses. They are don't-care when write_enable=0 but must be registered (no glitches).

Test Plan:
- Reset, then bytes 02 00 00 00 | 17 00 00 00 | 0B 00 00 00 one per cycle -> two write pulses: addr 0 data 23, then addr 1 data 11; done=1 one cycle after; loaded_words=2.
- Bytes spaced with idle gaps (rx_valid every 7 cycles), N=1, word E8 04 00 00 -> single write addr 0 data 1256, only after the 4th byte; no extra pulses.
- Count 01 04 00 00 (N=1025) with ADDR_WIDTH=10 -> err=1, no write_enable ever; following bytes ignored; start -> err=0, state LEN.
- N=0 -> done=1 with no writes. Then start, then N=1 word 7E 00 00 00 -> write addr 0 data 126.
- BASE_ADDR=147, N=1, word 02 00 00 00 -> write addr 147 data 2.
- rstn pulsed low after 6 data bytes of an N=3 load -> outputs 0 at once. After release, a fresh N=1 load writes addr 0.

Source files
------------

// File: rtl/prog_word_loader.sv
// prog_word_loader: assembles a little-endian UART byte stream
// (word count, then words) into single-cycle RAM write pulses.
module prog_word_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  start,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           data_write,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   loaded_words
);

  typedef enum logic [1:0] {
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERR
  } state_e;

  // Words that fit between BASE_ADDR and the top of the RAM
  localparam logic [32:0] CAP =
    33'((64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR));
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_e                state_q, state_d;
  logic [1:0]            bcnt_q;
  logic [31:0]           shift_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   idx_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;

  logic        take_len;
  logic        take_dat;
  logic        last;
  logic        rearm;
  logic [31:0] word;

  assign take_len = rx_valid && (state_q == S_LEN);
  assign take_dat = rx_valid && (state_q == S_DATA)
                 && (idx_q != len_q);
  assign last     = (bcnt_q == 2'd3);
  assign rearm    = start
                 && ((state_q == S_DONE) || (state_q == S_ERR));
  assign word     = {rx_data, shift_q[31:8]};

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_LEN;
    else       state_q <= state_d;
  end

  // Next-state: count decode in LEN, finish after the last write pulse
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LEN: begin
        if (take_len && last) begin
          if ({1'b0, word} > CAP) state_d = S_ERR;
          else if (word == 32'd0) state_d = S_DONE;
          else                    state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (we_q && (idx_q == len_q)) state_d = S_DONE;
      end
      S_DONE, S_ERR: begin
        if (start) state_d = S_LEN;
      end
    endcase
  end

  // Byte assembly, word count latch and registered RAM write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcnt_q  <= 2'd0;
      shift_q <= 32'd0;
      len_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 32'd0;
    end else if (rearm) begin
      bcnt_q <= 2'd0;
      idx_q  <= '0;
      we_q   <= 1'b0;
    end else begin
      we_q <= take_dat && last;
      if (take_len || take_dat) begin
        shift_q <= word;
        bcnt_q  <= bcnt_q + 2'd1;
      end
      if (take_len && last) len_q <= word[ADDR_WIDTH:0];
      if (take_dat && last) begin
        addr_q <= BASE + idx_q[ADDR_WIDTH-1:0];
        data_q <= word;
        idx_q  <= idx_q + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Status outputs decoded from registered state
  always_comb begin
    busy = (state_q == S_DATA)
        || ((state_q == S_LEN) && (bcnt_q != 2'd0));
    done = (state_q == S_DONE);
    err  = (state_q == S_ERR);
  end

  assign write_enable = we_q;
  assign addr         = addr_q;
  assign data_write   = data_q;
  assign loaded_words = idx_q;

endmodule

// File: tb/tb_prog_word_loader.sv
// tb_prog_word_loader: stream-level reference model against
// two loader instances (BASE_ADDR 0 and 147).
module tb_prog_word_loader;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        start = 1'b0;

  logic        we_a, busy_a, done_a, err_a;
  logic [9:0]  addr_a;
  logic [31:0] data_a;
  logic [10:0] lw_a;
  logic        we_b, busy_b, done_b, err_b;
  logic [9:0]  addr_b;
  logic [31:0] data_b;
  logic [10:0] lw_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_we_a = -10;
  int done_rise_a = -20;
  logic done_d = 1'b0;

  wr_t obs_a[$];
  wr_t obs_b[$];
  wr_t exp_q[$];
  bit  exp_err;
  bit  exp_done;

  prog_word_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid),
    .rx_data(rx_data), .start(start),
    .write_enable(we_a), .addr(addr_a), .data_write(data_a),
    .busy(busy_a), .done(done_a), .err(err_a),
    .loaded_words(lw_a)
  );

  prog_word_loader #(.ADDR_WIDTH(10), .BASE_ADDR(147)) dut_b (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid),
    .rx_data(rx_data), .start(start),
    .write_enable(we_b), .addr(addr_b), .data_write(data_b),
    .busy(busy_b), .done(done_b), .err(err_b),
    .loaded_words(lw_b)
  );

  always #5 clk = ~clk;

  // Write-pulse and done-edge monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    done_d <= done_a;
    if (done_a && !done_d) done_rise_a <= cyc;
    if (we_a) begin
      obs_a.push_back('{addr_a, data_a});
      last_we_a <= cyc;
    end
    if (we_b) obs_b.push_back('{addr_b, data_b});
  end

  // Reference: parse count and words straight from the byte list
  function automatic void model(input logic [7:0] s[$],
                                input int base, input int cap);
    longint unsigned n;
    exp_q.delete();
    n = {32'd0, s[3], s[2], s[1], s[0]};
    exp_err = (n > longint'(cap));
    exp_done = !exp_err && (s.size() >= 4 + 4 * int'(n));
    if (!exp_err)
      for (int i = 0; i < int'(n); i++) begin
        wr_t w;
        w.addr = 10'((base + i) % 1024);
        w.data = {s[4*i+7], s[4*i+6], s[4*i+5], s[4*i+4]};
        exp_q.push_back(w);
      end
  endfunction

  task automatic send(input logic [7:0] s[$], input int gap);
    foreach (s[i]) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = s[i];
      if (gap > 0) begin
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_obs();
    @(negedge clk);
    obs_a.delete();
    obs_b.delete();
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks += 8;
    if (we_a !== 1'b0) begin
      failures++; $display("FAIL reset_we got=%b exp=0", we_a);
    end
    if (addr_a !== 10'd0) begin
      failures++; $display("FAIL reset_addr got=%0d exp=0", addr_a);
    end
    if (data_a !== 32'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", data_a);
    end
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy_a);
    end
    if (done_a !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b exp=0", done_a);
    end
    if (err_a !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b exp=0", err_a);
    end
    if (lw_a !== 11'd0) begin
      failures++; $display("FAIL reset_lw got=%0d exp=0", lw_a);
    end
    if (busy_b !== 1'b0) begin
      failures++; $display("FAIL reset_busy_b got=%b exp=0", busy_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[$] = '{8'h02, 8'h00, 8'h00, 8'h00,
                         8'h17, 8'h00, 8'h00, 8'h00,
                         8'h0B, 8'h00, 8'h00, 8'h00};
    model(s, 0, 1024);
    clear_obs();
    send(s, 0);
    settle();
    checks++;
    if (obs_a.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=%0d",
               obs_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i].addr !== exp_q[i].addr
          || obs_a[i].data !== exp_q[i].data) begin
        failures++;
        $display("FAIL b2b_wr%0d got=%0d/%0d exp=%0d/%0d", i,
                 obs_a[i].addr, obs_a[i].data,
                 exp_q[i].addr, exp_q[i].data);
      end
    end
    checks += 4;
    if (lw_a !== 11'd2) begin
      failures++; $display("FAIL b2b_lw got=%0d exp=2", lw_a);
    end
    if (done_a !== exp_done) begin
      failures++; $display("FAIL b2b_done got=%b exp=%b", done_a, exp_done);
    end
    if (done_rise_a != last_we_a + 1) begin
      failures++;
      $display("FAIL b2b_done_lat got=%0d exp=%0d",
               done_rise_a - last_we_a, 1);
    end
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL b2b_busy got=%b exp=0", busy_a);
    end
    pulse_start();
  endtask

  task automatic test_gapped();
    logic [7:0] s[$] = '{8'h01, 8'h00, 8'h00, 8'h00,
                         8'hE8, 8'h04, 8'h00, 8'h00};
    logic [7:0] p1[$] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hE8};
    logic [7:0] p2[$] = '{8'h04, 8'h00};
    logic [7:0] p3[$] = '{8'h00};
    model(s, 0, 1024);
    clear_obs();
    send(p1, 6);
    checks++;
    if (busy_a !== 1'b1) begin
      failures++; $display("FAIL gap_busy got=%b exp=1", busy_a);
    end
    pulse_start();
    send(p2, 6);
    checks++;
    if (obs_a.size() != 0) begin
      failures++;
      $display("FAIL gap_early got=%0d exp=0", obs_a.size());
    end
    send(p3, 6);
    settle();
    checks++;
    if (obs_a.size() != 1) begin
      failures++;
      $display("FAIL gap_count got=%0d exp=1", obs_a.size());
    end else begin
      checks++;
      if (obs_a[0].addr !== exp_q[0].addr
          || obs_a[0].data !== exp_q[0].data) begin
        failures++;
        $display("FAIL gap_wr got=%0d/%0d exp=%0d/%0d",
                 obs_a[0].addr, obs_a[0].data,
                 exp_q[0].addr, exp_q[0].data);
      end
    end
    checks++;
    if (done_a !== 1'b1) begin
      failures++; $display("FAIL gap_done got=%b exp=1", done_a);
    end
    pulse_start();
  endtask

  task automatic test_overflow();
    logic [7:0] s[$] = '{8'h01, 8'h04, 8'h00, 8'h00};
    logic [7:0] junk[$] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h55};
    logic [7:0] ok[$] = '{8'h01, 8'h00, 8'h00, 8'h00,
                          8'hAA, 8'hBB, 8'hCC, 8'hDD};
    model(s, 0, 1024);
    clear_obs();
    send(s, 1);
    settle();
    checks += 3;
    if (err_a !== exp_err) begin
      failures++; $display("FAIL ovf_err got=%b exp=%b", err_a, exp_err);
    end
    if (err_b !== 1'b1) begin
      failures++; $display("FAIL ovf_err_b got=%b exp=1", err_b);
    end
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL ovf_busy got=%b exp=0", busy_a);
    end
    send(junk, 0);
    settle();
    checks += 3;
    if (obs_a.size() != 0) begin
      failures++;
      $display("FAIL ovf_writes got=%0d exp=0", obs_a.size());
    end
    if (err_a !== 1'b1) begin
      failures++; $display("FAIL ovf_hold got=%b exp=1", err_a);
    end
    if (lw_a !== 11'd0) begin
      failures++; $display("FAIL ovf_lw got=%0d exp=0", lw_a);
    end
    pulse_start();
    checks++;
    if (err_a !== 1'b0) begin
      failures++; $display("FAIL ovf_clear got=%b exp=0", err_a);
    end
    model(ok, 0, 1024);
    send(ok, 0);
    settle();
    checks++;
    if (obs_a.size() != 1 || obs_a[0].addr !== exp_q[0].addr
        || obs_a[0].data !== exp_q[0].data) begin
      failures++;
      $display("FAIL ovf_reload got=%0d writes exp=1 at %0d data %h",
               obs_a.size(), exp_q[0].addr, exp_q[0].data);
    end
    pulse_start();
  endtask

  task automatic test_zero();
    logic [7:0] z[$] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] s[$] = '{8'h01, 8'h00, 8'h00, 8'h00,
                         8'h7E, 8'h00, 8'h00, 8'h00};
    clear_obs();
    send(z, 0);
    settle();
    checks += 3;
    if (done_a !== 1'b1) begin
      failures++; $display("FAIL zero_done got=%b exp=1", done_a);
    end
    if (obs_a.size() != 0) begin
      failures++;
      $display("FAIL zero_writes got=%0d exp=0", obs_a.size());
    end
    if (lw_a !== 11'd0) begin
      failures++; $display("FAIL zero_lw got=%0d exp=0", lw_a);
    end
    @(negedge clk);
    start = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h05;
    @(negedge clk);
    start = 1'b0;
    rx_valid = 1'b0;
    checks += 2;
    if (done_a !== 1'b0) begin
      failures++; $display("FAIL zero_clear got=%b exp=0", done_a);
    end
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL zero_drop got=%b exp=0", busy_a);
    end
    model(s, 0, 1024);
    send(s, 0);
    settle();
    checks++;
    if (obs_a.size() != 1 || obs_a[0].addr !== exp_q[0].addr
        || obs_a[0].data !== exp_q[0].data) begin
      failures++;
      $display("FAIL zero_reload got=%0d writes exp=1 at %0d data %0d",
               obs_a.size(), exp_q[0].addr, exp_q[0].data);
    end
    pulse_start();
  endtask

  task automatic test_base();
    logic [7:0] s[$] = '{8'h01, 8'h00, 8'h00, 8'h00,
                         8'h02, 8'h00, 8'h00, 8'h00};
    model(s, 147, 877);
    clear_obs();
    send(s, 2);
    settle();
    checks++;
    if (obs_b.size() != 1) begin
      failures++;
      $display("FAIL base_count got=%0d exp=1", obs_b.size());
    end else begin
      checks++;
      if (obs_b[0].addr !== exp_q[0].addr
          || obs_b[0].data !== exp_q[0].data) begin
        failures++;
        $display("FAIL base_wr got=%0d/%0d exp=%0d/%0d",
                 obs_b[0].addr, obs_b[0].data,
                 exp_q[0].addr, exp_q[0].data);
      end
    end
    checks += 2;
    if (done_b !== 1'b1) begin
      failures++; $display("FAIL base_done got=%b exp=1", done_b);
    end
    if (lw_b !== 11'd1) begin
      failures++; $display("FAIL base_lw got=%0d exp=1", lw_b);
    end
    pulse_start();
  endtask

  task automatic test_reset_mid();
    logic [7:0] s[$] = '{8'h03, 8'h00, 8'h00, 8'h00,
                         8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] r[$] = '{8'h01, 8'h00, 8'h00, 8'h00,
                         8'h09, 8'h08, 8'h07, 8'h06};
    clear_obs();
    send(s, 0);
    checks += 2;
    if (lw_a !== 11'd1) begin
      failures++; $display("FAIL mid_pre_lw got=%0d exp=1", lw_a);
    end
    if (busy_a !== 1'b1) begin
      failures++; $display("FAIL mid_pre_busy got=%b exp=1", busy_a);
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks += 4;
    if (data_a !== 32'd0) begin
      failures++; $display("FAIL mid_data got=%h exp=0", data_a);
    end
    if (lw_a !== 11'd0) begin
      failures++; $display("FAIL mid_lw got=%0d exp=0", lw_a);
    end
    if (busy_a !== 1'b0) begin
      failures++; $display("FAIL mid_busy got=%b exp=0", busy_a);
    end
    if (we_a !== 1'b0) begin
      failures++; $display("FAIL mid_we got=%b exp=0", we_a);
    end
    @(negedge clk);
    rstn = 1'b1;
    model(r, 0, 1024);
    clear_obs();
    send(r, 0);
    settle();
    checks++;
    if (obs_a.size() != 1 || obs_a[0].addr !== exp_q[0].addr
        || obs_a[0].data !== exp_q[0].data) begin
      failures++;
      $display("FAIL mid_reload got=%0d writes exp=1 at %0d data %h",
               obs_a.size(), exp_q[0].addr, exp_q[0].data);
    end
    pulse_start();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] s[$];
      int n;
      int gap;
      n = $urandom_range(1, 8);
      gap = $urandom_range(0, 2);
      s.push_back(8'(n));
      s.push_back(8'd0);
      s.push_back(8'd0);
      s.push_back(8'd0);
      for (int k = 0; k < 4 * n; k++) s.push_back(8'($urandom));
      model(s, 0, 1024);
      clear_obs();
      send(s, gap);
      settle();
      checks++;
      if (obs_a.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rnd%0d_count got=%0d exp=%0d", it,
                 obs_a.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
        checks++;
        if (obs_a[i].addr !== exp_q[i].addr
            || obs_a[i].data !== exp_q[i].data) begin
          failures++;
          $display("FAIL rnd%0d_wr%0d got=%0d/%h exp=%0d/%h", it, i,
                   obs_a[i].addr, obs_a[i].data,
                   exp_q[i].addr, exp_q[i].data);
        end
      end
      checks += 2;
      if (lw_a !== 11'(n)) begin
        failures++; $display("FAIL rnd%0d_lw got=%0d exp=%0d", it, lw_a, n);
      end
      if (done_a !== exp_done) begin
        failures++;
        $display("FAIL rnd%0d_done got=%b exp=%b", it, done_a, exp_done);
      end
      pulse_start();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_overflow();
    test_zero();
    test_base();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
